isp_loader: RTL and testbench
=============================

// Module: isp_loader
// PURPOSE
//  Byte-stream-to-iram program loader; the AXI4-Lite write master that fills instruction memory during ISP.
//  Accepts bytes from the UART RX path, packs them little-endian into 32-bit words, and writes words to
//  consecutive iram addresses (user area 0x0000_0000 or ISP area 0x0800_0000) via AW/W/B channels.
//  Software in the bootrom configures base/length, pulses start, then polls busy/done/err/checksum.
// PARAMETERS
//  ADDR_W   32   AXI address width
//  LEN_W    16   width of word-count register (max 2^LEN_W-1 words per load)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  start_i      in   1       1-cycle pulse: latch base/len, begin load (ignored while busy_o=1)
//  abort_i      in   1       1-cycle pulse: stop load at next word boundary
//  base_addr_i  in   ADDR_W  first word address; bits [1:0] forced to 0
//  len_i        in   LEN_W   number of 32-bit words to load
//  rx_data_i    in   8       received byte
//  rx_valid_i   in   1       byte valid
//  rx_ready_o   out  1       byte accepted when rx_valid_i&rx_ready_o
//  m_awaddr     out  ADDR_W  write address
//  m_awprot     out  3       constant 3'b000
//  m_awvalid    out  1       write address valid
//  m_awready    in   1       write address ready
//  m_wdata      out  32      write data
//  m_wstrb      out  4       constant 4'hF
//  m_wvalid     out  1       write data valid
//  m_wready     in   1       write data ready
//  m_bresp      in   2       write response
//  m_bvalid     in   1       write response valid
//  m_bready     out  1       write response ready
//  busy_o       out  1       load in progress
//  done_o       out  1       1-cycle pulse at load end (normal, abort or len=0)
//  err_o        out  1       sticky: any bresp!=2'b00; cleared by next start_i
//  csum_o       out  32      sum mod 2^32 of all words written; cleared by start_i
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte/word counters 0.
//  FSM: IDLE -> COLLECT on start_i (len_i!=0); IDLE -> FIN on start_i with len_i==0.
//   COLLECT: rx_ready_o=1; each accepted byte shifts in at lane [8*k+7:8*k], k=0..3; 4th byte -> WRITE next cycle.
//   WRITE: m_awvalid=m_wvalid=1 same cycle; each drops independently after its own handshake; both done -> RESP.
//     awaddr/wdata stable while valid; no new bytes accepted (rx_ready_o=0).
//   RESP: m_bready=1; on m_bvalid: err|=(bresp!=0), csum+=wdata, addr+=4 (wraps mod 2^ADDR_W), words+=1;
//     words==len or abort pending -> FIN, else -> COLLECT.
//   FIN: done_o=1 for exactly one cycle, busy_o=0 next cycle, -> IDLE.
//  busy_o=1 in COLLECT/WRITE/RESP/FIN.
//  Latency: 4th byte accepted at cycle N -> valids high at N+1; min 3 cycles/word after last byte with zero-wait slave.
//  abort_i: in COLLECT -> FIN next cycle, partial word discarded; in WRITE/RESP -> latched, current
//   transaction completes (valids never withdrawn), then FIN; in IDLE/FIN ignored.
//  start_i while busy: ignored, latched parameters unchanged. start_i and abort_i same cycle in IDLE: start wins.
//  bvalid may arrive same cycle as aw/w handshake (iram holds bvalid high): count it only in RESP.
//  Reset mid-load: immediate return to IDLE, all valids drop asynchronously.
// STRUCTURE
//  Shared package isp_pkg: FSM state encoding, AXI_RESP_OKAY=2'b00, ISP_BASE=32'h0800_0000.
//  One natural sub-module: isp_byte_pack (byte counter + 32-bit shift register, clear, word_valid).
// TESTING
//  base=0x0, len=2, bytes 11 22 33 44 55 66 77 88 -> writes 0x44332211@0x0, 0x88776655@0x4; csum=0xCCAA8866; done pulse once.
//  AW ready 2 cycles before W ready -> awvalid drops after its handshake, wvalid holds; exactly one write issued.
//  bresp=2'b10 on word 1 of 3 -> err_o=1 sticky, load continues to 3 words; next start_i clears err_o.
//  len=0 start -> done_o pulses next cycle, zero AW/W handshakes, rx_ready_o never 1.
//  abort_i after 2 bytes of word 2 -> 1 write issued, done_o next cycle; abort during WRITE -> write completes first.
//  base=0xFFFF_FFFC, len=2 -> second awaddr=0x0000_0000; rst_n low mid-WRITE -> all outputs 0 immediately.

Source files
------------

// File: rtl/isp_pkg.sv
// ---------------------------------------------------------------------------
// isp_pkg
//   Shared definitions for the ISP program loader: FSM state encoding and the
//   AXI4-Lite constants used by the write master.
// ---------------------------------------------------------------------------
package isp_pkg;

    // Loader FSM states. The encoding is exported on the loader's debug port.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_RESP    = 3'd3,
        ST_FIN     = 3'd4
    } isp_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0]  AXI_PROT_NONE = 3'b000;
    localparam logic [3:0]  AXI_STRB_FULL = 4'hF;

    // Start of the ISP region of iram (user area starts at 0).
    localparam logic [31:0] ISP_BASE      = 32'h0800_0000;

endpackage

// File: rtl/isp_byte_pack.sv
// ---------------------------------------------------------------------------
// isp_byte_pack
//   Packs accepted bytes little-endian into a 32-bit word. Byte k of a word
//   ends up in lane [8*k+7:8*k]; word_valid_o fires combinationally on the
//   cycle the fourth byte is accepted, and the counter wraps so the next byte
//   starts a fresh word.
// Ports
//   clk, rst_n     clock, async active-low reset
//   clear_i        drop any partial word (counter back to 0)
//   byte_valid_i   a byte is being accepted this cycle
//   byte_i         the byte
//   word_o         packed word (stable until the next accepted byte)
//   word_valid_o   fourth byte of a word accepted this cycle
// ---------------------------------------------------------------------------
module isp_byte_pack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    // Bytes enter at the top and move down, so after four shifts the first
    // byte sits in lane 0 (little-endian).
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            word_d = {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/isp_loader.sv
// ---------------------------------------------------------------------------
// isp_loader
//   Byte-stream to iram program loader. Bytes from the UART RX path are packed
//   into 32-bit words and written to consecutive word addresses through an
//   AXI4-Lite write master (AW/W/B only). Bootrom software sets base/len,
//   pulses start_i, then polls busy_o/done_o/err_o/csum_o.
//
//   Handshake rule (all channels): a transfer happens on a rising clk edge
//   where valid && ready; a valid, once raised, is held with stable payload
//   until its own transfer, and never depends on the matching ready.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start_i, abort_i           control pulses
//   base_addr_i, len_i         first word address, number of words
//   rx_data_i/rx_valid_i/rx_ready_o   byte input stream
//   m_aw*, m_w*, m_b*          AXI4-Lite write master
//   busy_o, done_o, err_o, csum_o     status
//   state_o                    current FSM state (debug)
// ---------------------------------------------------------------------------
module isp_loader
    import isp_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [31:0]       csum_o,
    output isp_state_e        state_o
);

    isp_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              abort_q, abort_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;
    logic [31:0]       csum_q, csum_d;

    logic              pack_clear;
    logic              byte_fire;
    logic [31:0]       word;
    logic              word_valid;
    logic              aw_ok;
    logic              w_ok;

    assign byte_fire = rx_valid_i && rx_ready_o;

    isp_byte_pack u_pack (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pack_clear),
        .byte_valid_i (byte_fire),
        .byte_i       (rx_data_i),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // Outputs decoded from registered state only, so a reset drops every
    // valid immediately and no valid can be withdrawn by an input change.
    assign rx_ready_o = (state_q == ST_COLLECT);
    assign m_awvalid  = (state_q == ST_WRITE) && !aw_done_q;
    assign m_wvalid   = (state_q == ST_WRITE) && !w_done_q;
    assign m_bready   = (state_q == ST_RESP);
    assign m_awaddr   = addr_q;
    assign m_wdata    = word;
    assign m_awprot   = AXI_PROT_NONE;
    assign m_wstrb    = AXI_STRB_FULL;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_FIN);
    assign err_o      = err_q;
    assign csum_o     = csum_q;
    assign state_o    = state_q;

    // A channel counts as finished if it already handshook earlier in this
    // WRITE or handshakes on the current edge.
    assign aw_ok = aw_done_q || (m_awvalid && m_awready);
    assign w_ok  = w_done_q  || (m_wvalid  && m_wready);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        words_d    = words_q;
        abort_d    = abort_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        err_d      = err_q;
        csum_d     = csum_q;
        pack_clear = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // start_i has priority over abort_i, which is ignored here.
                if (start_i) begin
                    addr_d     = base_addr_i & ~ADDR_W'(3);
                    len_d      = len_i;
                    words_d    = '0;
                    abort_d    = 1'b0;
                    err_d      = 1'b0;
                    csum_d     = '0;
                    pack_clear = 1'b1;
                    state_d    = (len_i == '0) ? ST_FIN : ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                // Abort wins over a completing word; the partial word is lost.
                if (abort_i) begin
                    pack_clear = 1'b1;
                    state_d    = ST_FIN;
                end else if (word_valid) begin
                    state_d = ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                if (aw_ok && w_ok) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_RESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end

            ST_RESP: begin
                // bvalid seen outside RESP (slave holding it high) is never
                // counted; only the RESP-state handshake retires a word.
                if (abort_i) begin
                    abort_d = 1'b1;
                end
                if (m_bvalid) begin
                    err_d   = err_q | (m_bresp != AXI_RESP_OKAY);
                    csum_d  = csum_q + word;
                    addr_d  = addr_q + ADDR_W'(4);
                    words_d = words_q + LEN_W'(1);
                    if ((words_q + LEN_W'(1) == len_q) || abort_q || abort_i) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            words_q   <= '0;
            abort_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            csum_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            words_q   <= words_d;
            abort_q   <= abort_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            csum_q    <= csum_d;
        end
    end

endmodule

// File: tb/tb_isp_loader.sv
// ---------------------------------------------------------------------------
// tb_isp_loader
//   Directed bench for isp_loader. Expected writes (address, data) are queued
//   when the bytes are issued; a negedge monitor pairs AW/W handshakes and
//   pops/compares. A small AXI slave model applies per-channel ready delays
//   and an optional error response.
// ---------------------------------------------------------------------------
module tb_isp_loader;
    import isp_pkg::*;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       csum;
    isp_state_e        state;

    isp_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .base_addr_i (base),
        .len_i       (len),
        .rx_data_i   (rx_data),
        .rx_valid_i  (rx_valid),
        .rx_ready_o  (rx_ready),
        .m_awaddr    (m_awaddr),
        .m_awprot    (m_awprot),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_wvalid    (m_wvalid),
        .m_wready    (m_wready),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .csum_o      (csum),
        .state_o     (state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];
    int vectors  = 0;
    int errors   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_idx    = 0;
    int done_cnt = 0;
    int rx_seen  = 0;

    // slave model knobs
    int aw_delay = 0;
    int w_delay  = 0;
    int err_word = -1;
    int b_early  = 0;
    int aw_age   = 0;
    int w_age    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        forever begin
            tick();
            if (m_awvalid) begin
                m_awready = (aw_age >= aw_delay);
                aw_age++;
            end else begin
                m_awready = 1'b0;
                aw_age    = 0;
            end
            if (m_wvalid) begin
                m_wready = (w_age >= w_delay);
                w_age++;
            end else begin
                m_wready = 1'b0;
                w_age    = 0;
            end
            m_bvalid = (b_early != 0) ? (m_bready || m_awvalid || m_wvalid) : m_bready;
            m_bresp  = (b_idx == err_word) ? 2'b10 : 2'b00;
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        have_a;
        logic        have_w;
        logic [31:0] got_a;
        logic [31:0] got_d;
        logic [63:0] e;
        have_a = 1'b0;
        have_w = 1'b0;
        got_a  = '0;
        got_d  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_a = 1'b0;
                have_w = 1'b0;
            end else begin
                if (m_awvalid && m_awready) begin
                    aw_cnt++;
                    got_a  = m_awaddr;
                    have_a = 1'b1;
                end
                if (m_wvalid && m_wready) begin
                    w_cnt++;
                    got_d  = m_wdata;
                    have_w = 1'b1;
                end
                if (have_a && have_w) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", got_a, got_d);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", {32'h0, got_a}, {32'h0, e[63:32]});
                        check("wr_data", {32'h0, got_d}, {32'h0, e[31:0]});
                    end
                    have_a = 1'b0;
                    have_w = 1'b0;
                end
                if (m_bvalid && m_bready) b_idx++;
                if (done) done_cnt++;
                if (rx_ready) rx_seen = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        logic acc;
        rx_data  = b;
        rx_valid = 1'b1;
        acc      = 1'b0;
        n        = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = rx_ready;
            tick();
            n++;
        end
        rx_valid = 1'b0;
        if (!acc) check("rx_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic start_load(input logic [31:0] b, input logic [15:0] l);
        b_idx = 0;
        base  = b;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c0;
        int n;
        c0 = done_cnt;
        n  = 0;
        while (done_cnt == c0 && n < 400) begin
            tick();
            n++;
        end
        if (done_cnt == c0) check(name, 64'd0, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        int w0;
        int d0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        base     = '0;
        len      = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_outputs", {busy, done, m_awvalid, m_wvalid, m_bready, rx_ready, err}, 64'd0);
        check("rst_csum", csum, 64'd0);
        check("rst_awaddr", m_awaddr, 64'd0);
        check("rst_state", state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // T1: base 0, len 2, slave holds bvalid high throughout
        b_early = 1;
        push_exp(32'h0, 32'h4433_2211);
        push_exp(32'h4, 32'h8877_6655);
        d0 = done_cnt;
        a0 = aw_cnt;
        start_load(32'h0, 16'd2);
        check("t1_busy", busy, 64'd1);
        send_word(32'h4433_2211);
        check("t1_valid_latency", {m_awvalid, m_wvalid}, 64'd3);
        send_word(32'h8877_6655);
        wait_done("t1_done_timeout");
        check("t1_csum", csum, 64'hCCAA_8866);
        check("t1_err", err, 64'd0);
        check("t1_writes", aw_cnt - a0, 64'd2);
        check("t1_busy_after", busy, 64'd0);
        tick();
        check("t1_done_once", done_cnt - d0, 64'd1);
        b_early = 0;

        // T2: AW ready two cycles before W ready
        w_delay = 2;
        push_exp(32'h100, 32'hD4C3_B2A1);
        a0 = aw_cnt;
        w0 = w_cnt;
        start_load(32'h100, 16'd1);
        send_word(32'hD4C3_B2A1);
        tick();
        check("t2_aw_dropped", m_awvalid, 64'd0);
        check("t2_w_held", m_wvalid, 64'd1);
        wait_done("t2_done_timeout");
        check("t2_aw_count", aw_cnt - a0, 64'd1);
        check("t2_w_count", w_cnt - w0, 64'd1);
        w_delay = 0;

        // T3: error response on first of three words, ISP area
        err_word = 0;
        push_exp(ISP_BASE,      32'h0403_0201);
        push_exp(ISP_BASE + 4,  32'h0807_0605);
        push_exp(ISP_BASE + 8,  32'h0C0B_0A09);
        a0 = aw_cnt;
        start_load(ISP_BASE, 16'd3);
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        check("t3_err_mid", err, 64'd1);
        send_word(32'h0C0B_0A09);
        wait_done("t3_done_timeout");
        check("t3_err_sticky", err, 64'd1);
        check("t3_writes", aw_cnt - a0, 64'd3);
        check("t3_csum", csum, 64'h1815_120F);
        err_word = -1;

        // T4: len 0 -> immediate done, clears err/csum, no traffic
        a0      = aw_cnt;
        rx_seen = 0;
        start_load(32'h40, 16'd0);
        check("t4_done_next", done, 64'd1);
        check("t4_err_cleared", err, 64'd0);
        check("t4_csum_cleared", csum, 64'd0);
        tick();
        check("t4_done_pulse", {done, busy}, 64'd0);
        check("t4_no_writes", aw_cnt - a0, 64'd0);
        check("t4_no_rx_ready", rx_seen, 64'd0);

        // T5: abort after 2 bytes of word 2
        push_exp(32'h200, 32'h4030_2010);
        a0 = aw_cnt;
        start_load(32'h200, 16'd3);
        send_word(32'h4030_2010);
        send_byte(8'h50);
        send_byte(8'h60);
        pulse_abort();
        check("t5_done_next", done, 64'd1);
        tick();
        check("t5_idle", busy, 64'd0);
        check("t5_writes", aw_cnt - a0, 64'd1);
        check("t5_csum", csum, 64'h4030_2010);

        // T6: abort during WRITE -> write completes first
        w_delay = 3;
        push_exp(32'h300, 32'hEFBE_ADDE);
        a0 = aw_cnt;
        w0 = w_cnt;
        start_load(32'h300, 16'd3);
        send_word(32'hEFBE_ADDE);
        pulse_abort();
        check("t6_still_writing", m_wvalid, 64'd1);
        wait_done("t6_done_timeout");
        check("t6_w_done_before_fin", w_cnt - w0, 64'd1);
        check("t6_aw_count", aw_cnt - a0, 64'd1);
        check("t6_csum", csum, 64'hEFBE_ADDE);
        w_delay = 0;

        // T7: address wrap, low base bits ignored, start while busy ignored
        push_exp(32'hFFFF_FFFC, 32'hDDCC_BBAA);
        push_exp(32'h0000_0000, 32'h7856_3412);
        start_load(32'hFFFF_FFFF, 16'd2);
        send_byte(8'hAA);
        start_load(32'h500, 16'd0);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_word(32'h7856_3412);
        wait_done("t7_done_timeout");
        check("t7_csum", csum, 64'h5622_EFBC);

        // T8: reset asserted mid-WRITE drops everything at once
        aw_delay = 5;
        w_delay  = 5;
        start_load(32'h400, 16'd1);
        send_word(32'h1234_5678);
        check("t8_in_write", {m_awvalid, m_wvalid}, 64'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("t8_valids_low", {m_awvalid, m_wvalid, m_bready, busy, done, rx_ready}, 64'd0);
        check("t8_awaddr_low", m_awaddr, 64'd0);
        check("t8_wdata_low", m_wdata, 64'd0);
        check("t8_state_idle", state, ST_IDLE);
        tick();
        rst_n    = 1'b1;
        aw_delay = 0;
        w_delay  = 0;
        repeat (2) tick();

        check("exp_q_drained", exp_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
